// File: rtl/sseg_pkg.sv
// Shared types, constants and anode decode for the seven-segment scan driver.
// Optional dimming fields exist only when SSEG_DIM_EN is defined.
package sseg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned BRIGHT_W   = 4;

    localparam logic [SEG_W-1:0]      SEG_OFF = 8'hFF;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = 4'hF;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // Per-frame copy of everything the scan displays.
    typedef struct packed {
        logic [NUM_DIGITS-1:0][SEG_W-1:0] pat;
        logic [NUM_DIGITS-1:0]            en;
`ifdef SSEG_DIM_EN
        logic [BRIGHT_W-1:0]              bright;
`endif
    } snap_t;

    // Active-low one-hot anode select for a digit index.
    function automatic logic [NUM_DIGITS-1:0] sel_decode(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Pattern-source / display-pin bundle for sseg_scan_driver.
// Carries brightness only when SSEG_DIM_EN is defined.
interface sseg_scan_driver_if;
    import sseg_pkg::*;

    logic [SEG_W-1:0]      in0;
    logic [SEG_W-1:0]      in1;
    logic [SEG_W-1:0]      in2;
    logic [SEG_W-1:0]      in3;
    logic [NUM_DIGITS-1:0] digit_en;
`ifdef SSEG_DIM_EN
    logic [BRIGHT_W-1:0]   brightness;
`endif
    logic [NUM_DIGITS-1:0] sel;
    logic [SEG_W-1:0]      sseg;
    logic                  frame_start;

    modport master (
        output in0, in1, in2, in3, digit_en,
`ifdef SSEG_DIM_EN
        output brightness,
`endif
        input  sel, sseg, frame_start
    );

    modport slave (
        input  in0, in1, in2, in3, digit_en,
`ifdef SSEG_DIM_EN
        input  brightness,
`endif
        output sel, sseg, frame_start
    );

endinterface

// File: rtl/sseg_scan_driver_slot_timer.sv
// Mod-N phase timer: counts 0..limit, pulses terminal count, and loads the
// next phase's limit on that same edge so BLANK and DRIVE share one counter.
module slot_timer #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned RST_LIMIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tc_c_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q, limit_d;

    assign tc_c_o = (count_q == limit_q);

    // Wrap at terminal count and take the limit for the phase being entered.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        limit_d = limit_q;
        if (tc_c_o) begin
            count_d = '0;
            limit_d = limit_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            limit_q <= CNT_W'(RST_LIMIT);
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode scan driver with inter-digit blanking and per-frame
// input snapshot. Define SSEG_DIM_EN to add PWM brightness control.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS = 50_000,
    parameter int unsigned BLANK_TICKS = 500
) (
    input  logic                clk,
    input  logic                reset_n,
    sseg_scan_driver_if.slave   bus
);

    localparam int unsigned MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    snap_t                 snap_q, snap_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [SEG_W-1:0]      sseg_q, sseg_d;
    logic                  fs_q, fs_d;
`ifdef SSEG_DIM_EN
    logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
`endif

    logic                  tc_c;
    logic [CNT_W-1:0]      next_limit_c;

    // Only consumed at terminal count, where the phase always flips.
    assign next_limit_c = (state_q == BLANK) ? CNT_W'(DIGIT_TICKS - 1)
                                             : CNT_W'(BLANK_TICKS - 1);

    slot_timer #(
        .CNT_W     (CNT_W),
        .RST_LIMIT (BLANK_TICKS - 1)
    ) u_slot_timer (
        .clk     (clk),
        .rst_n   (reset_n),
        .limit_i (next_limit_c),
        .tc_c_o  (tc_c)
    );

    // Next state and next outputs; outputs derive from the _d values so the
    // registered pins line up with the state they describe.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        sel_d   = SEL_OFF;
        sseg_d  = SEG_OFF;
        fs_d    = 1'b0;
`ifdef SSEG_DIM_EN
        pwm_d   = pwm_q;
`endif

        case (state_q)
            BLANK: begin
                if (tc_c) begin
                    state_d = DRIVE;
`ifdef SSEG_DIM_EN
                    pwm_d   = '0;
`endif
                    if (idx_q == '0) begin
                        snap_d.pat = {bus.in3, bus.in2, bus.in1, bus.in0};
                        snap_d.en  = bus.digit_en;
`ifdef SSEG_DIM_EN
                        snap_d.bright = bus.brightness;
`endif
                        fs_d = 1'b1;
                    end
                end
            end
            DRIVE: begin
`ifdef SSEG_DIM_EN
                pwm_d = pwm_q + BRIGHT_W'(1);
`endif
                if (tc_c) begin
                    state_d = BLANK;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: state_d = BLANK;
        endcase

        if ((state_d == DRIVE) && snap_d.en[idx_d]) begin
            sel_d  = sel_decode(idx_d);
            sseg_d = snap_d.pat[idx_d];
        end

`ifdef SSEG_DIM_EN
        // Dark part of the PWM period within a driven slot.
        if (pwm_d > snap_d.bright) begin
            sel_d  = SEL_OFF;
            sseg_d = SEG_OFF;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= BLANK;
            idx_q       <= '0;
            snap_q.pat  <= {NUM_DIGITS{SEG_OFF}};
            snap_q.en   <= '0;
`ifdef SSEG_DIM_EN
            snap_q.bright <= '0;
            pwm_q       <= '0;
`endif
            sel_q       <= SEL_OFF;
            sseg_q      <= SEG_OFF;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
`ifdef SSEG_DIM_EN
            pwm_q       <= pwm_d;
`endif
            sel_q       <= sel_d;
            sseg_q      <= sseg_d;
            fs_q        <= fs_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.sseg        = sseg_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with DIGIT_TICKS=8, BLANK_TICKS=2.
// A timeline scoreboard predicts every output cycle; SSEG_DIM_EN adds brightness runs.
module tb_sseg_scan_driver;
    import sseg_pkg::*;

    localparam int unsigned DT    = 8;
    localparam int unsigned BT    = 2;
    localparam int         SLOT   = 10;
    localparam int         FRAME  = 40;

    logic clk = 1'b0;
    logic reset_n;

    sseg_scan_driver_if bus();

    sseg_scan_driver #(
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int t      = 0;

    // Scoreboard copy of the frame snapshot and running trackers.
    logic [7:0] cur_pat [4];
    logic [3:0] cur_en;
`ifdef SSEG_DIM_EN
    logic [3:0] cur_br;
`endif
    int         last_fs;
    int         blank_run;
    bit         have_active;
    logic [3:0] prev_sel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, got, exp);
    endtask

    // Compare all outputs against the position of cycle t in the frame.
    task automatic sample();
        int  f;
        int  slot;
        int  p;
        bit  drive;
        logic [3:0] exp_sel;
        logic [7:0] exp_sseg;
        f    = t % FRAME;
        slot = f / SLOT;
        p    = f % SLOT;
        if (f == 2) begin
            cur_pat[0] = bus.in0;
            cur_pat[1] = bus.in1;
            cur_pat[2] = bus.in2;
            cur_pat[3] = bus.in3;
            cur_en     = bus.digit_en;
`ifdef SSEG_DIM_EN
            cur_br     = bus.brightness;
`endif
        end
        drive = (p >= 2) && cur_en[slot];
`ifdef SSEG_DIM_EN
        if ((p - 2) > int'(cur_br)) drive = 1'b0;
`endif
        exp_sel  = drive ? ~(4'b0001 << slot) : 4'hF;
        exp_sseg = drive ? cur_pat[slot] : 8'hFF;
        check("sel",  32'(bus.sel),  32'(exp_sel));
        check("sseg", 32'(bus.sseg), 32'(exp_sseg));
        check("frame_start", 32'(bus.frame_start), 32'(f == 2));
        check("onehot", 32'($countones(~bus.sel) <= 1), 32'(1));
        if (bus.frame_start) begin
            if (last_fs >= 0) check("fs_period", 32'(t - last_fs), 32'(FRAME));
            last_fs = t;
        end
        if (bus.sel == 4'hF) blank_run++;
        else begin
            if (bus.sel != prev_sel && have_active) check("gap", 32'(blank_run >= 2), 32'(1));
            have_active = 1'b1;
            blank_run   = 0;
        end
        prev_sel = bus.sel;
    endtask

    task automatic step();
        @(negedge clk);
        t++;
        sample();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Hold reset a few cycles, check reset outputs, release on a falling edge.
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sel",  32'(bus.sel),  32'(4'hF));
        check("rst_sseg", 32'(bus.sseg), 32'(8'hFF));
        check("rst_fs",   32'(bus.frame_start), 32'(0));
        reset_n     = 1'b1;
        t           = 0;
        last_fs     = -1;
        blank_run   = 0;
        have_active = 1'b0;
        prev_sel    = 4'hF;
        sample();
    endtask

    task automatic set_inputs(input logic [7:0] a, b, c, d, input logic [3:0] en);
        bus.in0      = a;
        bus.in1      = b;
        bus.in2      = c;
        bus.in3      = d;
        bus.digit_en = en;
    endtask

    initial begin
        reset_n = 1'b0;
`ifdef SSEG_DIM_EN
        bus.brightness = 4'hF;
`endif

        // Uniform pattern, all digits enabled; two frames.
        set_inputs(8'h9C, 8'h9C, 8'h9C, 8'h9C, 4'hF);
        do_reset();
        step();
        check("t1_blank_sel", 32'(bus.sel), 32'(4'hF));
        step();
        check("t1_first_fs",   32'(bus.frame_start), 32'(1));
        check("t1_first_sel",  32'(bus.sel),  32'(4'b1110));
        check("t1_first_sseg", 32'(bus.sseg), 32'(8'h9C));
        run(10);
        check("t1_d1_sel", 32'(bus.sel), 32'(4'b1101));
        run(FRAME * 2 - 12);

        // Mid-frame change on in3 stays hidden until the next snapshot.
        set_inputs(8'hC0, 8'hF9, 8'hA4, 8'hFF, 4'hF);
        do_reset();
        run(14);
        bus.in3 = 8'hE2;
        run(35 - 14);
        check("t2_old_d3", 32'(bus.sseg), 32'(8'hFF));
        check("t2_old_sel", 32'(bus.sel), 32'(4'b0111));
        run(FRAME);
        check("t2_new_d3", 32'(bus.sseg), 32'(8'hE2));
        run(10);

        // Digits 1 and 3 disabled.
        set_inputs(8'h92, 8'h82, 8'hF8, 8'h80, 4'b0101);
        do_reset();
        run(15);
        check("t3_d1_off_sel",  32'(bus.sel),  32'(4'hF));
        check("t3_d1_off_sseg", 32'(bus.sseg), 32'(8'hFF));
        run(FRAME * 2 - 15);

        // Asynchronous reset in the middle of digit 2.
        set_inputs(8'h88, 8'h83, 8'hC6, 8'hA1, 4'hF);
        do_reset();
        run(25);
        check("t4_pre_sel", 32'(bus.sel), 32'(4'b1011));
        #2 reset_n = 1'b0;
        #1;
        check("t4_async_sel",  32'(bus.sel),  32'(4'hF));
        check("t4_async_sseg", 32'(bus.sseg), 32'(8'hFF));
        check("t4_async_fs",   32'(bus.frame_start), 32'(0));
        do_reset();
        run(FRAME + 5);

        // Long run: one-hot, blanking gap and frame period every frame.
        set_inputs(8'h86, 8'h8E, 8'hC2, 8'h89, 4'hF);
        run(FRAME * 1000);

`ifdef SSEG_DIM_EN
        // Brightness 3: driven for slot cycles 0-3 only.
        bus.brightness = 4'd3;
        do_reset();
        run(5);
        check("t6_b3_on",  32'(bus.sel), 32'(4'b1110));
        run(1);
        check("t6_b3_off", 32'(bus.sel), 32'(4'hF));
        run(FRAME * 2 - 6);
        bus.brightness = 4'd15;
        do_reset();
        run(9);
        check("t6_b15_last", 32'(bus.sel), 32'(4'b1110));
        run(FRAME * 2 - 9);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
